// File: rtl/main_mem_model.sv
// Behavioural line-granular main memory behind the memory arbiter.
// One transaction in flight: reads return BEATS beats after LATENCY cycles; writes absorb BEATS masked beats.

module main_mem_model_lane #(
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wbyte,
  input  logic             re,
  input  logic [IDX_W-1:0] ridx,
  output logic [7:0]       rbyte
);
  logic [7:0] store [2**IDX_W];

  // Storage survives reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) store[widx] <= wbyte;
  end

  always_ff @(posedge clk) begin
    if (reset)   rbyte <= '0;
    else if (re) rbyte <= store[ridx];
  end
endmodule

module main_mem_model #(
  parameter int ADDR_BITS  = 28,
  parameter int TAG_BITS   = 5,
  parameter int DATA_BITS  = 128,
  parameter int BEATS      = 4,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [TAG_BITS-1:0]    mem_resp_tag
);
  localparam int LANES  = DATA_BITS / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = DEPTH_LOG2 + BEAT_W;
  localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, WDATA} state_t;

  typedef struct packed {
    logic [DEPTH_LOG2-1:0] line;
    logic [TAG_BITS-1:0]   tag;
  } req_t;

  state_t            state, next_state;
  req_t              req_q;
  logic [BEAT_W-1:0] beat, rd_beat;
  logic [CNT_W-1:0]  cnt;
  logic              req_fire, beat_fire, last_beat;
  logic              req_ready_d, data_ready_d, resp_valid_d;
  logic              wr_en, rd_en;
  logic [IDX_W-1:0]  widx, ridx;
  logic [DEPTH_LOG2-1:0]   rd_line;
  logic [LANES-1:0][7:0]   wr_bytes, rd_bytes;
  logic                    unused_addr;

  assign unused_addr = ^mem_req_addr;

  assign req_fire  = mem_req_valid && mem_req_ready;
  assign beat_fire = mem_req_data_valid && mem_req_data_ready;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_fire) next_state = mem_req_rw ? WDATA : ((LATENCY == 1) ? RESP : WAIT);
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    if (last_beat) next_state = IDLE;
      WDATA:   if (beat_fire && last_beat) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so nothing is combinational to the ports.
  always_comb begin
    req_ready_d  = (next_state == IDLE);
    data_ready_d = (next_state == WDATA);
    resp_valid_d = (next_state == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_ready      <= 1'b0;
      mem_req_data_ready <= 1'b0;
      mem_resp_valid     <= 1'b0;
    end else begin
      mem_req_ready      <= req_ready_d;
      mem_req_data_ready <= data_ready_d;
      mem_resp_valid     <= resp_valid_d;
    end
  end

  // WAIT lasts LATENCY-1 cycles so the first beat lands LATENCY cycles after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
      beat  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (req_fire) begin
          req_q.line <= mem_req_addr[DEPTH_LOG2-1:0];
          req_q.tag  <= mem_req_tag;
          beat       <= '0;
          cnt        <= CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);
        end
        WAIT:    cnt  <= cnt - CNT_W'(1);
        RESP:    beat <= last_beat ? '0 : beat + BEAT_W'(1);
        WDATA:   if (beat_fire) beat <= last_beat ? '0 : beat + BEAT_W'(1);
        default: beat <= '0;
      endcase
    end
  end

  assign wr_en    = (state == WDATA) && beat_fire && !reset;
  assign widx     = {req_q.line, beat};
  assign wr_bytes = mem_req_data_bits;

  // Fetch one beat ahead so the registered read data lines up with mem_resp_valid.
  assign rd_en   = resp_valid_d && !reset;
  assign rd_beat = (state == RESP) ? beat + BEAT_W'(1) : '0;
  assign rd_line = (state == IDLE) ? mem_req_addr[DEPTH_LOG2-1:0] : req_q.line;
  assign ridx    = {rd_line, rd_beat};

  always_ff @(posedge clk) begin
    if (reset)      mem_resp_tag <= '0;
    else if (rd_en) mem_resp_tag <= (state == IDLE) ? mem_req_tag : req_q.tag;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    main_mem_model_lane #(.IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en && mem_req_data_mask[i]),
      .widx  (widx),
      .wbyte (wr_bytes[i]),
      .re    (rd_en),
      .ridx  (ridx),
      .rbyte (rd_bytes[i])
    );
  end

  assign mem_resp_data = rd_bytes;
endmodule

// File: tb/tb_main_mem_model.sv
// Scoreboard bench for main_mem_model: stimulus queues expected beats, a negedge monitor checks them.

module tb_main_mem_model;
  localparam int AB = 28, TW = 5, DB = 128, BEATS = 4, LAT = 8;
  localparam int MB = DB / 8;

  logic          clk = 1'b0, reset = 1'b1;
  logic          mem_req_valid = 1'b0, mem_req_rw = 1'b0;
  logic [AB-1:0] mem_req_addr = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic          mem_req_data_valid = 1'b0;
  logic [DB-1:0] mem_req_data_bits = '0;
  logic [MB-1:0] mem_req_data_mask = '0;
  logic          mem_req_ready, mem_req_data_ready, mem_resp_valid;
  logic [DB-1:0] mem_resp_data;
  logic [TW-1:0] mem_resp_tag;

  main_mem_model dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_rw         (mem_req_rw),
    .mem_req_addr       (mem_req_addr),
    .mem_req_tag        (mem_req_tag),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data),
    .mem_resp_tag       (mem_resp_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DB-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%h required=none", mem_resp_data);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", mem_resp_data, e.data);
        chk("resp_tag", DB'(mem_resp_tag), DB'(e.tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic rw, input logic [AB-1:0] a, input logic [TW-1:0] t, output int acc);
    int n = 0;
    mem_req_valid = 1'b1;
    mem_req_rw    = rw;
    mem_req_addr  = a;
    mem_req_tag   = t;
    while (!mem_req_ready && n < 100) begin tick(); n++; end
    if (!mem_req_ready) begin
      checks++; failures++;
      $display("FAIL req_timeout actual=%0d required=ready", n);
    end
    acc = cyc;
    tick();
    mem_req_valid = 1'b0;
  endtask

  task automatic write_line(input logic [AB-1:0] a, input logic [BEATS-1:0][DB-1:0] d,
                            input logic [BEATS-1:0][MB-1:0] m, input int gap);
    int t, n, w;
    request(1'b1, a, '0, t);
    chk("data_ready_at_T+1", DB'(mem_req_data_ready), DB'(1));
    // Hold a competing read request to prove nothing is accepted mid-write.
    mem_req_valid = (gap > 0);
    mem_req_rw    = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          mem_req_data_valid = 1'b0;
          chk("no_accept_in_wdata", DB'(mem_req_ready), DB'(0));
          tick();
        end
      end
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = d[b];
      mem_req_data_mask  = m[b];
      n = 0;
      while (!mem_req_data_ready && n < 50) begin tick(); n++; end
      if (!mem_req_data_ready) begin
        checks++; failures++;
        $display("FAIL data_ready_timeout actual=%0d required=ready", n);
      end
      w = cyc;
      tick();
    end
    mem_req_data_valid = 1'b0;
    mem_req_valid      = 1'b0;
    chk("ready_after_last_beat", DB'(mem_req_ready), DB'(1));
    if (gap == 0) chk("write_last_beat_cycle", DB'(w - t), DB'(BEATS));
  endtask

  task automatic read_line(input logic [AB-1:0] a, input logic [TW-1:0] t,
                           input logic [BEATS-1:0][DB-1:0] e);
    int acc, n;
    for (int b = 0; b < BEATS; b++) exp_q.push_back('{data: e[b], tag: t});
    request(1'b0, a, t, acc);
    n = 0;
    while (!mem_resp_valid && n < 50) begin tick(); n++; end
    chk("first_beat_latency", DB'(cyc - acc), DB'(LAT));
    n = 0;
    while (!mem_req_ready && n < 50) begin tick(); n++; end
    chk("ready_return", DB'(cyc - acc), DB'(LAT + BEATS));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [BEATS-1:0][DB-1:0] d, e;
    logic [BEATS-1:0][MB-1:0] m, mfull;
    int acc, n;
    mfull = '1;

    repeat (3) tick();
    chk("ready_in_reset", DB'(mem_req_ready), DB'(0));
    chk("resp_valid_in_reset", DB'(mem_resp_valid), DB'(0));
    chk("data_ready_in_reset", DB'(mem_req_data_ready), DB'(0));
    reset = 1'b0;
    tick();
    chk("ready_after_reset", DB'(mem_req_ready), DB'(1));
    chk("resp_data_reset", mem_resp_data, '0);
    chk("resp_tag_reset", DB'(mem_resp_tag), '0);
    for (int i = 0; i < 20; i++) begin
      chk("idle_resp_valid", DB'(mem_resp_valid), DB'(0));
      chk("idle_data_ready", DB'(mem_req_data_ready), DB'(0));
      tick();
    end

    for (int b = 0; b < BEATS; b++) d[b] = {120'h0123456789ABCDEF_FEDCBA98765432, 8'(8'hA0 + b)};
    write_line(28'h10, d, mfull, 0);
    read_line(28'h10, 5'd5, d);

    d = '1;
    write_line(28'h20, d, mfull, 0);
    d = '0;
    m = '0;
    m[1] = 16'h00FF;
    write_line(28'h20, d, m, 0);
    e = '1;
    e[1] = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    read_line(28'h20, 5'd7, e);

    for (int b = 0; b < BEATS; b++) d[b] = {4{32'h5A5A_0000 | 32'(b)}};
    write_line(28'h30, d, mfull, 3);
    read_line(28'h30, 5'd9, d);

    for (int b = 0; b < BEATS; b++) d[b] = {4{32'hC3C3_0100 | 32'(b)}};
    write_line(28'h1010, d, mfull, 0);
    read_line(28'h0010, 5'd11, d);

    for (int b = 0; b < BEATS; b++) d[b] = {4{32'h7E7E_0200 | 32'(b)}};
    write_line(28'h40, d, mfull, 0);
    for (int b = 0; b < BEATS; b++) exp_q.push_back('{data: d[b], tag: 5'd2});
    request(1'b0, 28'h40, 5'd2, acc);
    n = 0;
    while (!mem_resp_valid && n < 50) begin tick(); n++; end
    tick();
    chk("second_beat_valid", DB'(mem_resp_valid), DB'(1));
    reset = 1'b1;
    tick();
    chk("valid_after_mid_reset", DB'(mem_resp_valid), DB'(0));
    chk("ready_during_mid_reset", DB'(mem_req_ready), DB'(0));
    reset = 1'b0;
    tick();
    chk("ready_after_mid_reset", DB'(mem_req_ready), DB'(1));
    chk("abandoned_beats", DB'(exp_q.size()), DB'(2));
    exp_q.delete();
    read_line(28'h40, 5'd3, d);

    repeat (5) tick();
    chk("queue_drained", DB'(exp_q.size()), DB'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
